// File: rtl/systolic_multiplier_ctrl.sv
// systolic_multiplier_ctrl: load/clear/shift sequencer for a systolic multiplier with abort and result handshake
// Define SYSTOLIC_MULT_AUTO_ACK_EN to make DONE a single-cycle pulse that needs no acknowledge.
module systolic_multiplier_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PIPE_STAGES = 2,
  localparam int CW = $clog2(DATA_WIDTH + PIPE_STAGES + 1)
) (
  input  logic          i_CLK,
  input  logic          i_RESET,
  input  logic          i_CLK_ENABLE,
  input  logic          i_BEGIN_MULT,
  input  logic          i_RESULT_ACK,
  input  logic          i_ABORT,
  output logic          o_SHIFT_REG_LOAD,
  output logic          o_ACC_CLEAR,
  output logic          o_SHIFT_EN,
  output logic          o_RESULT_READY,
  output logic          o_BUSY,
  output logic [CW-1:0] o_CALC_COUNT
);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH + PIPE_STAGES - 1);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_exit;
`ifdef SYSTOLIC_MULT_AUTO_ACK_EN
  assign done_exit = 1'b1;
`else
  assign done_exit = i_RESULT_ACK;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      IDLE: state_d = i_BEGIN_MULT ? LOAD : IDLE;
      LOAD: state_d = i_ABORT ? IDLE : CALC;
      CALC: begin
        state_d = i_ABORT ? IDLE : (cnt_q == LAST) ? DONE : CALC;
        cnt_d = (i_ABORT || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
      default: state_d = !done_exit ? DONE : i_BEGIN_MULT ? LOAD : IDLE;
    endcase
  end
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else if (i_CLK_ENABLE) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign o_SHIFT_REG_LOAD = state_q == LOAD;
  assign o_ACC_CLEAR = state_q == LOAD;
  assign o_SHIFT_EN = state_q == CALC;
  assign o_RESULT_READY = state_q == DONE;
  assign o_BUSY = state_q == LOAD || state_q == CALC;
  assign o_CALC_COUNT = state_q == CALC ? cnt_q : '0;
endmodule

// File: tb/tb_systolic_multiplier_ctrl.sv
// tb_systolic_multiplier_ctrl: vector table plus scoreboard for the default controller, hand sequence for a 16/0 instance
module tb_systolic_multiplier_ctrl;
  localparam int N = 10;
  localparam int I = 0, L = 1, C = 2, D = 3;
  typedef struct {logic rst, en, beg, ack, abt; int st; int cnt;} vec_t;
  logic clk = 1'b0;
  logic rst, en, beg, ack, abt, beg16, ack16;
  logic load, clr, sh, rdy, busy;
  logic [3:0] cnt;
  logic load16, clr16, sh16, rdy16, busy16;
  logic [4:0] cnt16;
  int errors = 0, checks = 0;
  vec_t v[$];
  logic [8:0] sb[$];
  always #5 clk = ~clk;
  systolic_multiplier_ctrl dut (
    .i_CLK(clk), .i_RESET(rst), .i_CLK_ENABLE(en), .i_BEGIN_MULT(beg),
    .i_RESULT_ACK(ack), .i_ABORT(abt), .o_SHIFT_REG_LOAD(load), .o_ACC_CLEAR(clr),
    .o_SHIFT_EN(sh), .o_RESULT_READY(rdy), .o_BUSY(busy), .o_CALC_COUNT(cnt)
  );
  systolic_multiplier_ctrl #(.DATA_WIDTH(16), .PIPE_STAGES(0)) u16 (
    .i_CLK(clk), .i_RESET(rst), .i_CLK_ENABLE(en), .i_BEGIN_MULT(beg16),
    .i_RESULT_ACK(ack16), .i_ABORT(1'b0), .o_SHIFT_REG_LOAD(load16), .o_ACC_CLEAR(clr16),
    .o_SHIFT_EN(sh16), .o_RESULT_READY(rdy16), .o_BUSY(busy16), .o_CALC_COUNT(cnt16)
  );
  function automatic logic [8:0] expo(int st, int c);
    return {st == L, st == L, st == C, st == D, st == L || st == C, 4'(c)};
  endfunction
  task automatic add(logic r, logic e, logic b, logic a, logic x, int s, int c);
    v.push_back('{r, e, b, a, x, s, c});
  endtask
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic tick16(logic b, logic a);
    beg16 = b;
    ack16 = a;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; en = 1'b1; beg = 1'b0; ack = 1'b0; abt = 1'b0; beg16 = 1'b0; ack16 = 1'b0;
    add(1, 1, 0, 0, 0, I, 0);
    add(1, 0, 0, 0, 0, I, 0);
    add(0, 1, 0, 0, 1, I, 0);
    add(0, 1, 0, 1, 0, I, 0);
    add(0, 0, 1, 0, 0, I, 0);
    // basic run with begin/ack noise during CALC and DONE holding
    add(0, 1, 1, 0, 0, L, 0);
    for (int i = 0; i < N; i++) add(0, 1, i == 3, i == 5, 0, C, i);
    add(0, 1, 0, 0, 0, D, 0);
`ifndef SYSTOLIC_MULT_AUTO_ACK_EN
    add(0, 1, 0, 0, 1, D, 0);
    add(0, 1, 1, 0, 0, D, 0);
`endif
    add(0, 0, 0, 1, 0, D, 0);
    add(0, 1, 0, 1, 0, I, 0);
    // clock enable toggling every other edge, abort on disabled edges ignored
    add(0, 1, 1, 0, 0, L, 0);
    add(0, 0, 0, 0, 0, L, 0);
    for (int i = 0; i < N; i++) begin
      add(0, 1, 0, 0, 0, C, i);
      add(0, 0, 0, 0, 1, C, i);
    end
    add(0, 1, 0, 0, 0, D, 0);
    // back-to-back: ack with begin goes straight to LOAD
    add(0, 1, 1, 1, 0, L, 0);
    for (int i = 0; i < N; i++) add(0, 1, 0, 0, 0, C, i);
    add(0, 1, 0, 1, 0, I, 0 + 0);
    v[v.size()-1].st = D;
    add(0, 1, 0, 1, 0, I, 0);
    // abort at count 4, then abort in LOAD
    add(0, 1, 1, 0, 0, L, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, C, i);
    add(0, 1, 0, 0, 1, I, 0);
    add(0, 1, 0, 0, 0, I, 0);
    add(0, 1, 1, 0, 0, L, 0);
    add(0, 1, 1, 0, 1, I, 0);
    add(0, 1, 0, 0, 0, I, 0);
    // reset with clock disabled mid-CALC, then reset in DONE
    add(0, 1, 1, 0, 0, L, 0);
    add(0, 1, 0, 0, 0, C, 0);
    add(0, 1, 0, 0, 0, C, 1);
    add(1, 0, 0, 0, 0, I, 0);
    add(0, 1, 0, 0, 0, I, 0);
    add(0, 1, 1, 0, 0, L, 0);
    for (int i = 0; i < N; i++) add(0, 1, 0, 0, 0, C, i);
    add(0, 1, 0, 0, 0, D, 0);
    add(1, 1, 1, 1, 0, I, 0);
    add(0, 1, 0, 0, 0, I, 0);
    foreach (v[i]) begin
      rst = v[i].rst; en = v[i].en; beg = v[i].beg; ack = v[i].ack; abt = v[i].abt;
      sb.push_back(expo(v[i].st, v[i].cnt));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {load, clr, sh, rdy, busy, cnt}, sb.pop_front());
    end
    rst = 1'b0; en = 1'b1; beg = 1'b0; ack = 1'b0; abt = 1'b0;
    tick16(1, 0);
    chk("u16_load", {load16, clr16, sh16, rdy16, busy16, cnt16}, {5'b11001, 5'd0});
    for (int i = 0; i < 16; i++) begin
      tick16(0, 0);
      chk($sformatf("u16_calc%0d", i), {load16, clr16, sh16, rdy16, busy16, cnt16}, {5'b00101, 5'(i)});
    end
    tick16(0, 0);
    chk("u16_ready", {load16, clr16, sh16, rdy16, busy16, cnt16}, {5'b00010, 5'd0});
`ifdef SYSTOLIC_MULT_AUTO_ACK_EN
    tick16(0, 0);
    chk("u16_pulse_end", {load16, clr16, sh16, rdy16, busy16, cnt16}, 10'd0);
`else
    tick16(0, 0);
    chk("u16_ready_hold", {load16, clr16, sh16, rdy16, busy16, cnt16}, {5'b00010, 5'd0});
    tick16(0, 1);
    chk("u16_ack_idle", {load16, clr16, sh16, rdy16, busy16, cnt16}, 10'd0);
`endif
    tick16(0, 0);
    chk("u16_idle", {load16, clr16, sh16, rdy16, busy16, cnt16}, 10'd0);
    chk("main_idle", {load, clr, sh, rdy, busy, cnt}, 9'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
